// File: rtl/tx_line_pkg.sv
// Shared types and character constants for the line transmitter and receiver.
package tx_line_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_LOAD      = 4'd2,
        ST_SEND      = 4'd3,
        ST_WAIT_ACK  = 4'd4,
        ST_WAIT_DONE = 4'd5,
        ST_EOL_CR    = 4'd6,
        ST_EOL_LF    = 4'd7,
        ST_FINISH    = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        ITEM_PAYLOAD = 2'd0,
        ITEM_CR      = 2'd1,
        ITEM_LF      = 2'd2
    } item_e;

    localparam logic [7:0] CHAR_NUL = 8'h00;
    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;

    // Payload stops at the terminator or once the length cap has been reached.
    function automatic logic end_of_payload(input logic [7:0] data,
                                            input logic [7:0] count,
                                            input logic [7:0] max_len);
        return (data == CHAR_NUL) || (count == max_len);
    endfunction

endpackage

// File: rtl/tx_line_handshake.sv
// Byte handshake with the UART TX: start strobe, wait for tx_done to fall
// (bounded by a timeout), then wait for it to rise again.
module tx_handshake
    import tx_line_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic req_i,
    input  logic clr_err_i,
    input  logic tx_done_i,
    output logic ack_o,
    output logic err_o,
    output logic tx_start_o,
    output logic tx_error_o
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tx_start_q, tx_start_d;
    logic             tx_error_q, tx_error_d;
    logic             waiting_ack_s;
    logic             timeout_s;

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q    <= ST_IDLE;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
            tx_error_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
            tx_error_q <= tx_error_d;
        end
    end

    // Next phase; a tx_done already low during the strobe cycle counts as the ack.
    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            ST_IDLE: begin
                if (req_i) phase_d = ST_SEND;
                else       phase_d = ST_IDLE;
            end
            ST_SEND, ST_WAIT_ACK: begin
                if (!tx_done_i)           phase_d = ST_WAIT_DONE;
                else if (cnt_q == CNT_LAST) phase_d = ST_IDLE;
                else                      phase_d = ST_WAIT_ACK;
            end
            ST_WAIT_DONE: begin
                if (tx_done_i) phase_d = ST_IDLE;
                else           phase_d = ST_WAIT_DONE;
            end
            default: phase_d = ST_IDLE;
        endcase
    end

    // Strobe, timeout counter, sticky error and the ack/err pulses to the line FSM.
    always_comb begin
        waiting_ack_s = (phase_q == ST_SEND) || (phase_q == ST_WAIT_ACK);
        timeout_s     = waiting_ack_s && tx_done_i && (cnt_q == CNT_LAST);
        ack_o         = (phase_q == ST_WAIT_DONE) && tx_done_i;
        err_o         = timeout_s;
        tx_start_d    = (phase_q == ST_IDLE) && req_i;

        if (phase_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (waiting_ack_s && tx_done_i && !timeout_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (clr_err_i) begin
            tx_error_d = 1'b0;
        end else if (timeout_s) begin
            tx_error_d = 1'b1;
        end else begin
            tx_error_d = tx_error_q;
        end
    end

    assign tx_start_o = tx_start_q;
    assign tx_error_o = tx_error_q;

endmodule

// File: rtl/tx_line.sv
// Line transmitter: reads a NUL-terminated string from a synchronous-read RAM
// and feeds it byte by byte to the UART TX, followed by CR and optional LF.
module tx_line
    import tx_line_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int APPEND_LF   = 1,
    parameter int MAX_LEN     = 255,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_read,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_done,
    output logic              busy,
    output logic              tx_line_done,
    output logic              tx_error,
    output logic [7:0]        sent_count
);

    localparam logic [7:0] MAX_LEN_C = 8'(MAX_LEN);

    state_e            state_q, state_d;
    item_e             item_q, item_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        sent_count_q, sent_count_d;
    logic              busy_q, busy_d;
    logic              line_done_q, line_done_d;
    logic              eop_s;
    logic              req_s;
    logic              clr_err_s;
    logic              hs_ack_s;
    logic              hs_err_s;

    assign eop_s = end_of_payload(data_read, sent_count_q, MAX_LEN_C);

    // State and registered outputs; reset aborts any line in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            item_q       <= ITEM_PAYLOAD;
            addr_q       <= '0;
            tx_data_q    <= 8'h00;
            sent_count_q <= 8'd0;
            busy_q       <= 1'b0;
            line_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            item_q       <= item_d;
            addr_q       <= addr_d;
            tx_data_q    <= tx_data_d;
            sent_count_q <= sent_count_d;
            busy_q       <= busy_d;
            line_done_q  <= line_done_d;
        end
    end

    // Next state; ST_SEND covers the whole handshake until ack or err.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
                else       state_d = ST_IDLE;
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                if (eop_s) state_d = ST_EOL_CR;
                else       state_d = ST_SEND;
            end
            ST_SEND: begin
                if (hs_err_s) begin
                    state_d = ST_FINISH;
                end else if (hs_ack_s) begin
                    case (item_q)
                        ITEM_PAYLOAD: state_d = ST_FETCH;
                        ITEM_CR:      state_d = (APPEND_LF != 0) ? ST_EOL_LF : ST_FINISH;
                        ITEM_LF:      state_d = ST_FINISH;
                        default:      state_d = ST_FINISH;
                    endcase
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_EOL_CR: state_d = ST_SEND;
            ST_EOL_LF: state_d = ST_SEND;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        item_d       = item_q;
        addr_d       = addr_q;
        tx_data_d    = tx_data_q;
        sent_count_d = sent_count_q;
        clr_err_s    = 1'b0;
        busy_d       = (state_d != ST_IDLE);
        line_done_d  = (state_d == ST_FINISH);
        req_s        = (state_q != ST_SEND) && (state_d == ST_SEND);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d       = start_addr;
                    sent_count_d = 8'd0;
                    clr_err_s    = 1'b1;
                end else begin
                    addr_d = addr_q;
                end
            end
            ST_LOAD: begin
                if (!eop_s) begin
                    tx_data_d = data_read;
                    item_d    = ITEM_PAYLOAD;
                end else begin
                    tx_data_d = tx_data_q;
                end
            end
            ST_EOL_CR: begin
                tx_data_d = CHAR_CR;
                item_d    = ITEM_CR;
            end
            ST_EOL_LF: begin
                tx_data_d = CHAR_LF;
                item_d    = ITEM_LF;
            end
            ST_SEND: begin
                if (!hs_err_s && hs_ack_s && (item_q == ITEM_PAYLOAD)) begin
                    addr_d       = addr_q + ADDR_W'(1);
                    sent_count_d = sent_count_q + 8'd1;
                end else begin
                    addr_d = addr_q;
                end
            end
            default: begin
                item_d = item_q;
            end
        endcase
    end

    tx_handshake #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_handshake (
        .clock      (clock),
        .reset      (reset),
        .req_i      (req_s),
        .clr_err_i  (clr_err_s),
        .tx_done_i  (tx_done),
        .ack_o      (hs_ack_s),
        .err_o      (hs_err_s),
        .tx_start_o (tx_start),
        .tx_error_o (tx_error)
    );

    assign addr         = addr_q;
    assign tx_data      = tx_data_q;
    assign busy         = busy_q;
    assign tx_line_done = line_done_q;
    assign sent_count   = sent_count_q;

endmodule

// File: doc/tx_line.md
Name: tx_line

Overview:
Line transmitter; the counterpart of the line receiver. On a start pulse it reads a NUL-terminated string from the shared synchronous-read RAM, beginning at start_addr. It passes each byte to the UART transmitter, then sends an end-of-line sequence (CR, plus optional LF) and pulses tx_line_done. It sits between the RAM read port and the UART TX byte interface.

Parameters:
ADDR_W, 8, RAM address width; addresses wrap modulo 2^ADDR_W.
APPEND_LF, 1, when 1, send 0x0A after the 0x0D terminator.
MAX_LEN, 255, maximum payload bytes before a forced end-of-line (1..2^ADDR_W-1).
ACK_TIMEOUT, 16, maximum cycles to wait for tx_done to fall after tx_start.

Ports:
clock  in  1  system clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request to send a line; ignored unless idle.
start_addr  in  ADDR_W  first RAM address of the string; sampled together with start.
addr  out  ADDR_W  RAM read address.
data_read  in  8  RAM read data; valid the cycle after addr is presented.
tx_data  out  8  byte handed to the UART TX.
tx_start  out  1  one-cycle strobe: UART TX accepts tx_data.
tx_done  in  1  UART TX status: 1 = idle/finished, 0 = transmitting.
busy  out  1  high from the start-accept edge until return to IDLE.
tx_line_done  out  1  one-cycle pulse when the line is fully sent.
tx_error  out  1  set on ack timeout; cleared on the next accepted start.
sent_count  out  8  payload bytes sent in the current/last line, excluding CR/LF.

Behaviour:
- Reset values: addr=0, tx_data=0, tx_start=0, busy=0, tx_line_done=0, tx_error=0, sent_count=0, state=IDLE. Reset mid-line aborts immediately; no partial end-of-line is sent.
- All outputs are registered.
- States: IDLE, FETCH, LOAD, SEND, WAIT_ACK, WAIT_DONE, EOL_CR, EOL_LF, FINISH.
- IDLE: on start=1, latch addr<=start_addr, sent_count<=0, tx_error<=0, busy<=1, then go to FETCH.
- FETCH: one cycle while the RAM registers addr; then go to LOAD.
- LOAD: data_read is valid.
  - If data_read==0x00 or sent_count==MAX_LEN, go to EOL_CR.
  - Otherwise tx_data<=data_read, go to SEND.
- SEND: tx_start=1 for exactly this cycle; go to WAIT_ACK.
- WAIT_ACK: wait for tx_done==0.
  - If it stays high for ACK_TIMEOUT cycles: tx_error<=1, go to FINISH. No end-of-line is sent.
- WAIT_DONE: wait for tx_done==1, with no timeout.
  - After a payload byte: addr<=addr+1 (wraps), sent_count+=1, go to FETCH.
  - After CR: go to EOL_LF if APPEND_LF, else FINISH.
  - After LF: go to FINISH.
- EOL_CR: tx_data<=0x0D, go to SEND. EOL_LF: tx_data<=0x0A, go to SEND.
- FINISH: tx_line_done=1 for one cycle, busy<=0, go to IDLE.
- Latency: start sampled at edge N; addr valid after N; first tx_start is high in cycle N+3.
- Per-byte overhead: 3 cycles plus the UART busy time.
- start asserted while busy is ignored; no queueing.
- tx_done already low at SEND: counts as the ack on the next cycle.
- The addr write side of the RAM is not driven here; integration ties the RAM write enable low while tx_line owns the port.

Decomposition:
- Shared package: the state enum, CHAR_NUL=0x00, CHAR_CR=0x0D, CHAR_LF=0x0A. The receiver uses the same constants.
- One sub-module, tx_handshake: owns the SEND/WAIT_ACK/WAIT_DONE strobe, the timeout counter and the error flag. The main FSM sees a req/ack/err interface.

Test Plan:
- RAM[1..3]=48 49 00, start_addr=1 -> tx_data sequence 48,49,0D,0A; one tx_line_done pulse; sent_count=2; tx_error=0.
- RAM[0x10]=00 -> only 0D,0A sent; sent_count=0; addr stays 0x10.
- start_addr=0xFE, RAM[FE]=41, RAM[FF]=42, RAM[00]=00 -> addr sequence FE,FF,00; sends 41,42,0D,0A.
- MAX_LEN=4, RAM[0..7]=61..68 (no NUL) -> sends 61,62,63,64,0D,0A; sent_count=4.
- UART model holds tx_done=1 after tx_start -> tx_error=1 exactly 16 cycles after the first strobe; tx_line_done pulses; nothing further sent; the next start clears tx_error.
- Assert reset during the second byte's WAIT_DONE -> all outputs return to reset values asynchronously; a later start from 1 resends the full line; a start pulse while busy is ignored.
